// File: rtl/mux_scan_reg.sv
// -----------------------------------------------------------------------------
// mux_scan_reg
// Registered N:1 data multiplexer with manual-select and auto-scan modes.
// In auto-scan the block rotates upward through the channels enabled in
// i_mask, holding each one for DWELL cycles. o_y always tracks the live data
// of the channel currently shown on o_ch.
//
// Ports
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_en     : block enable; 0 freezes outputs, counter and state
//   i_mode   : 0 = manual select, 1 = auto-scan
//   i_sel    : manual channel select
//   i_mask   : auto-scan channel enables, bit k = channel k
//   i_d      : flat data bus, channel k at [k*DW +: DW]
//   o_y      : registered selected data
//   o_ch     : channel index currently driven on o_y
//   o_valid  : o_y holds legal channel data
//   o_wrap   : one-cycle pulse when the scan wraps to its lowest channel
// -----------------------------------------------------------------------------
module mux_scan_reg #(
  parameter int DW    = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH),
  parameter int DWELL = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [SELW-1:0]   i_sel,
  input  logic [NCH-1:0]    i_mask,
  input  logic [NCH*DW-1:0] i_d,
  output logic [DW-1:0]     o_y,
  output logic [SELW-1:0]   o_ch,
  output logic              o_valid,
  output logic              o_wrap
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam int            CW       = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [1:0]      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   y_n;
  logic [SELW-1:0] ch_n;
  logic            valid_n, wrap_n;
  logic            cur_en;
  logic [SELW:0]   found_at, found_above;

  // Data of channel idx; an index beyond the last channel yields zero.
  function automatic logic [DW-1:0] pick(input logic [NCH*DW-1:0] d,
                                         input logic [SELW-1:0]   idx);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++)
      if (int'(idx) == k) r = d[k*DW +: DW];
    return r;
  endfunction

  // Lowest enabled channel >= start; if there is none, the lowest enabled
  // channel overall with the top bit set to flag that the search wrapped.
  // Only meaningful when mask is non-zero.
  function automatic logic [SELW:0] search(input logic [NCH-1:0] mask,
                                           input int              start);
    logic          found;
    logic [SELW:0] r;
    found = 1'b0;
    r     = '0;
    for (int k = 0; k < NCH; k++)
      if (!found && mask[k] && k >= start) begin
        r     = {1'b0, SELW'(k)};
        found = 1'b1;
      end
    for (int k = 0; k < NCH; k++)
      if (!found && mask[k]) begin
        r     = {1'b1, SELW'(k)};
        found = 1'b1;
      end
    return r;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers latches.
    state_n = state;
    cnt_n   = cnt;
    y_n     = o_y;
    ch_n    = o_ch;
    valid_n = o_valid;
    wrap_n  = 1'b0;

    cur_en = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (int'(o_ch) == k && i_mask[k]) cur_en = 1'b1;

    // "at" seeds a scan entered from another mode; "above" is the rotation.
    found_at    = search(i_mask, int'(o_ch));
    found_above = search(i_mask, int'(o_ch) + 1);

    if (i_en) begin
      if (!i_mode) begin
        state_n = ST_MANUAL;
        cnt_n   = '0;
        ch_n    = i_sel;
        if (int'(i_sel) < NCH) begin
          y_n     = pick(i_d, i_sel);
          valid_n = 1'b1;
        end else begin
          y_n     = '0;
          valid_n = 1'b0;
        end
      end else begin
        state_n = ST_SCAN;
        cnt_n   = '0;
        if (i_mask == '0) begin
          // Nothing to show: park on the current channel, counter held at 0.
          y_n     = '0;
          valid_n = 1'b0;
        end else if (state != ST_SCAN) begin
          // A mode change takes priority over any pending advance: no wrap.
          ch_n    = found_at[SELW-1:0];
          y_n     = pick(i_d, found_at[SELW-1:0]);
          valid_n = 1'b1;
        end else if (!cur_en || cnt == CNT_LAST) begin
          // Dwell expired, or the shown channel was just masked off.
          ch_n    = found_above[SELW-1:0];
          y_n     = pick(i_d, found_above[SELW-1:0]);
          wrap_n  = found_above[SELW];
          valid_n = 1'b1;
        end else begin
          cnt_n   = cnt + 1'b1;
          y_n     = pick(i_d, o_ch);
          valid_n = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      o_y     <= '0;
      o_ch    <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      o_y     <= y_n;
      o_ch    <= ch_n;
      o_valid <= valid_n;
      o_wrap  <= wrap_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_reg
// Self-checking bench for mux_scan_reg (DW=4, NCH=4, DWELL=4). A table of
// manual-mode vectors, directed multi-cycle scan sequences, an asynchronous
// reset, then randomized traffic compared every cycle against a behavioural
// model built from the channel list and a per-channel dwell age.
// -----------------------------------------------------------------------------
module tb_mux_scan_reg;

  localparam int DW    = 4;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int DWELL = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              en    = 1'b0;
  logic              mode  = 1'b0;
  logic [SELW-1:0]   sel   = '0;
  logic [NCH-1:0]    mask  = '0;
  logic [NCH*DW-1:0] d     = '0;
  logic [DW-1:0]     y;
  logic [SELW-1:0]   ch;
  logic              valid, wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_scan_reg #(.DW(DW), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .i_mode (mode),
    .i_sel  (sel),
    .i_mask (mask),
    .i_d    (d),
    .o_y    (y),
    .o_ch   (ch),
    .o_valid(valid),
    .o_wrap (wrap)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_MAN, M_SCAN} mstate_t;
  mstate_t m_state;
  int      m_ch, m_age, m_y, m_valid, m_wrap;

  function automatic int chan(int c);
    return (int'(d) >> (c * DW)) & ((1 << DW) - 1);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_ch = 0; m_age = 0; m_y = 0; m_valid = 0; m_wrap = 0;
  endtask

  // One rising edge with the inputs currently applied.
  task automatic model_edge();
    int lst[$];
    int nxt;
    for (int k = 0; k < NCH; k++) if (mask[k]) lst.push_back(k);
    m_wrap = 0;
    if (!en) return;
    if (!mode) begin
      m_state = M_MAN;
      m_age   = 0;
      m_ch    = int'(sel);
      m_valid = (m_ch < NCH) ? 1 : 0;
      m_y     = m_valid ? chan(m_ch) : 0;
    end else if (lst.size() == 0) begin
      m_state = M_SCAN;
      m_age   = 0;
      m_y     = 0;
      m_valid = 0;
    end else begin
      if (m_state != M_SCAN) begin
        nxt = -1;
        foreach (lst[j]) if (nxt < 0 && lst[j] >= m_ch) nxt = lst[j];
        if (nxt < 0) nxt = lst[0];
        m_ch  = nxt;
        m_age = 0;
      end else if (!mask[m_ch] || m_age == DWELL - 1) begin
        nxt = -1;
        foreach (lst[j]) if (nxt < 0 && lst[j] > m_ch) nxt = lst[j];
        if (nxt < 0) begin
          nxt    = lst[0];
          m_wrap = 1;
        end
        m_ch  = nxt;
        m_age = 0;
      end else begin
        m_age++;
      end
      m_state = M_SCAN;
      m_y     = chan(m_ch);
      m_valid = 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_y"},     int'(y),     m_y);
    check({tag, "_ch"},    int'(ch),    m_ch);
    check({tag, "_valid"}, int'(valid), m_valid);
    check({tag, "_wrap"},  int'(wrap),  m_wrap);
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  // ---------------- manual-mode vector table ----------------
  typedef struct {
    logic            en;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [DW-1:0]   exp_y;
    logic [SELW-1:0] exp_ch;
    logic            exp_valid;
    logic            exp_wrap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int wraps;
    int exp_ch;

    // en, mode, sel -> y, ch, valid, wrap   (data = {3,2,1,0})
    vecs[0] = '{1'b1, 1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 4'd1, 2'd1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 4'd2, 2'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 4'd3, 2'd3, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'd1, 4'd3, 2'd3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 4'd1, 2'd1, 1'b1, 1'b0};

    // ---- reset ----
    d = 16'h3210;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_y", int'(y), 0);
    check("rst_ch", int'(ch), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_wrap", int'(wrap), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("idle_valid", int'(valid), 0);

    // ---- 1: manual select table ----
    foreach (vecs[i]) begin
      en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel;
      step();
      check($sformatf("vec%0d_y", i),     int'(y),     int'(vecs[i].exp_y));
      check($sformatf("vec%0d_ch", i),    int'(ch),    int'(vecs[i].exp_ch));
      check($sformatf("vec%0d_valid", i), int'(valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_wrap", i),  int'(wrap),  int'(vecs[i].exp_wrap));
    end

    // ---- 2: full-mask scan 0,1,2,3,0 each held DWELL cycles ----
    en = 1'b1; mode = 1'b0; sel = 2'd0;
    step();
    check_model("t2_pre");
    mode = 1'b1; mask = 4'b1111;
    wraps = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check_model("t2");
      check("t2_ch_seq", int'(ch), ((i - 1) / DWELL) % NCH);
      check("t2_wrap_seq", int'(wrap), (i == 17) ? 1 : 0);
      if (wrap) wraps++;
    end
    check("t2_wrap_count", wraps, 1);

    // ---- 3: mask 1010 -> channels 1,3,1,3 ----
    mask = 4'b1010;
    for (int j = 1; j <= 16; j++) begin
      step();
      check_model("t3");
      exp_ch = (((j - 1) / DWELL) % 2 == 1) ? 3 : 1;
      check("t3_ch_seq", int'(ch), exp_ch);
      check("t3_y_seq", int'(y), exp_ch);
      check("t3_wrap_seq", int'(wrap), (j == 9) ? 1 : 0);
    end

    // ---- 4: empty mask, then a single-channel mask ----
    mask = 4'b0000;
    step();
    check_model("t4_empty");
    check("t4_empty_valid", int'(valid), 0);
    check("t4_empty_y", int'(y), 0);
    mask = 4'b0100;
    step();
    check_model("t4_restore");
    check("t4_restore_ch", int'(ch), 2);
    check("t4_restore_y", int'(y), 2);
    check("t4_restore_valid", int'(valid), 1);

    // ---- 5: freeze mid-dwell at count 2, resume ----
    step();
    step();
    check_model("t5_pre");
    en = 1'b0; mask = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      check_model("t5_frozen");
      check("t5_frozen_ch", int'(ch), 2);
      check("t5_frozen_wrap", int'(wrap), 0);
    end
    en = 1'b1;
    step();
    check_model("t5_resume1");
    check("t5_resume1_ch", int'(ch), 2);
    step();
    check_model("t5_resume2");
    check("t5_resume2_ch", int'(ch), 3);

    // ---- 6: async reset between edges ----
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_y", int'(y), 0);
    check("t6_async_ch", int'(ch), 0);
    check("t6_async_valid", int'(valid), 0);
    check("t6_async_wrap", int'(wrap), 0);
    en = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_model("t6_idle");
    end
    en = 1'b1;
    step();
    check_model("t6_start");
    check("t6_start_ch", int'(ch), 0);
    check("t6_start_valid", int'(valid), 1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = SELW'($urandom);
      if ($urandom_range(0, 7) == 0) mask = NCH'($urandom);
      if ($urandom_range(0, 3) == 0) d = (NCH*DW)'($urandom);
      step();
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
